x_input_loader: RTL and testbench

- Receiving end of the matrix byte-stream protocol: start_in / valid_input / X_load in, finish out.
- Accepts BYTES_PER_MATRIX bytes per matrix and packs every 4 bytes into a 32-bit word.
- Writes the words into the matrix SRAM through a cs_n/ry write port.
- Raises finish once every word of a matrix is committed, so the source may send the next matrix.

---
 rtl/x_input_loader_if.sv | 27 ++
 rtl/x_input_loader.sv | 140 ++++++++++++++
 tb/tb_x_input_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/x_input_loader_if.sv
// Byte-stream in / SRAM write port out bundle for the X matrix loader.
// Write handshake: mem_cs_n=0 is "valid"; addr/wdata hold until a posedge sees mem_ry=1 ("ready").
interface x_input_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start_in;
    logic              valid_input;
    logic [7:0]        X_load;
    logic              mem_ry;
    logic              mem_cs_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              finish;
    logic              all_done;
    logic              overflow;

    modport master (
        output start_in, valid_input, X_load, mem_ry,
        input  mem_cs_n, mem_we_n, mem_addr, mem_wdata, finish, all_done, overflow
    );

    modport slave (
        input  start_in, valid_input, X_load, mem_ry,
        output mem_cs_n, mem_we_n, mem_addr, mem_wdata, finish, all_done, overflow
    );
endinterface

// File: rtl/x_input_loader.sv
// Packs incoming bytes MSB-first into 32-bit words and writes them to the matrix SRAM
// through a 2-entry word FIFO; signals finish per matrix and all_done after NUM_MATRIX.
module x_input_loader #(
    parameter int NUM_MATRIX       = 2,
    parameter int BYTES_PER_MATRIX = 32,
    parameter int ADDR_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    x_input_loader_if.slave        bus,
    output logic [2:0]             state_dbg_o
);
    localparam int BCW = $clog2(BYTES_PER_MATRIX);
    localparam int MW  = $clog2(NUM_MATRIX + 1);
    localparam int WPM = BYTES_PER_MATRIX / 4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WAIT, S_DONE} state_e;

    state_e            state_q;
    logic [BCW-1:0]    byte_cnt_q;
    logic [23:0]       part_q;
    logic [MW-1:0]     matrix_idx_q;
    logic [ADDR_W-1:0] fifo_addr_q [2];
    logic [31:0]       fifo_data_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              cs_n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              finish_q;
    logic              all_done_q;
    logic              overflow_q;

    logic              byte_en;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              last_byte;
    logic [ADDR_W-1:0] push_addr;

    always_comb begin
        byte_en   = (state_q == S_LOAD) && bus.valid_input;
        push      = byte_en && (byte_cnt_q[1:0] == 2'b11);
        // A new word may be issued whenever the port is idle or the current write is accepted.
        pop       = (cnt_q != 2'd0) && (cs_n_q || bus.mem_ry);
        push_ok   = push && ((cnt_q != 2'd2) || pop);
        last_byte = byte_en && (byte_cnt_q == BCW'(BYTES_PER_MATRIX - 1));
        push_addr = ADDR_W'(matrix_idx_q) * ADDR_W'(WPM) + ADDR_W'(byte_cnt_q >> 2);
        cnt_d     = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            part_q       <= '0;
            matrix_idx_q <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            cs_n_q       <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            finish_q     <= 1'b0;
            all_done_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (byte_en) begin
                part_q     <= {part_q[15:0], bus.X_load};
                byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
            end

            // Dropped words still consume their address slot via byte_cnt.
            if (push_ok) begin
                fifo_addr_q[wr_ptr_q] <= push_addr;
                fifo_data_q[wr_ptr_q] <= {part_q, bus.X_load};
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end

            if (pop) begin
                addr_q   <= fifo_addr_q[rd_ptr_q];
                wdata_q  <= fifo_data_q[rd_ptr_q];
                cs_n_q   <= 1'b0;
                rd_ptr_q <= ~rd_ptr_q;
            end else if (!cs_n_q && bus.mem_ry) begin
                cs_n_q <= 1'b1;
            end
            cnt_q <= cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (bus.start_in) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (last_byte) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((cnt_q == 2'd0) && cs_n_q) begin
                        finish_q     <= 1'b1;
                        matrix_idx_q <= matrix_idx_q + 1'b1;
                        if (matrix_idx_q == MW'(NUM_MATRIX - 1)) begin
                            all_done_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.start_in) begin
                        finish_q <= 1'b0;
                        state_q  <= S_LOAD;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_cs_n  = cs_n_q;
    assign bus.mem_we_n  = cs_n_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.finish    = finish_q;
    assign bus.all_done  = all_done_q;
    assign bus.overflow  = overflow_q;
    assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_x_input_loader.sv
// Directed-plus-random bench for x_input_loader: expected SRAM writes come from packing the
// sent bytes into words in the bench and are matched against every accepted write.
module tb_x_input_loader;
  localparam int WPM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ry_lo = 0;
  int ry_hi = 0;
  int cs_low_cnt = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  cur[32];
  logic        stall_prev = 1'b0;
  logic [39:0] held;

  x_input_loader_if #(.ADDR_W(8)) bus();

  x_input_loader #(.NUM_MATRIX(2), .BYTES_PER_MATRIX(32), .ADDR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mem_ry is low only inside the [ry_lo, ry_hi) cycle window of the current matrix.
  task automatic step();
    bus.mem_ry = !(cyc >= ry_lo && cyc < ry_hi);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.start_in = 1'b0;
    bus.valid_input = 1'b0;
    bus.X_load = 8'h00;
    ry_lo = 0;
    ry_hi = 0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"}, bus.mem_cs_n, 1'b1);
    check({tag, "_we_n"}, bus.mem_we_n, 1'b1);
    check({tag, "_addr"}, bus.mem_addr, 8'h00);
    check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    check({tag, "_finish"}, bus.finish, 1'b0);
    check({tag, "_all_done"}, bus.all_done, 1'b0);
    check({tag, "_overflow"}, bus.overflow, 1'b0);
  endtask

  task automatic start_pulse();
    bus.start_in = 1'b1;
    step();
    bus.start_in = 1'b0;
    cyc = 0;
  endtask

  task automatic fill_seq(input logic [7:0] base);
    for (int i = 0; i < 32; i++) cur[i] = base + 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) cur[i] = 8'($urandom_range(0, 255));
  endtask

  // Word w of matrix m holds bytes 4w..4w+3, first byte in the top lane.
  task automatic expect_words(input int m, input int n);
    for (int w = 0; w < n; w++)
      exp_q.push_back({8'(m * WPM + w), cur[4*w], cur[4*w+1], cur[4*w+2], cur[4*w+3]});
  endtask

  task automatic send_bytes(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          bus.valid_input = 1'b0;
          bus.X_load = 8'($urandom_range(0, 255));
          step();
        end
      end
      bus.valid_input = 1'b1;
      bus.X_load = cur[i];
      step();
    end
    bus.valid_input = 1'b0;
  endtask

  task automatic idle_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.valid_input = 1'(i % 2 == 0);
      bus.X_load = 8'($urandom_range(0, 255));
      step();
    end
    bus.valid_input = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (bus.finish !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check(tag, bus.finish, 1'b1);
  endtask

  // Accepted writes are seen at the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.mem_cs_n === 1'b0) cs_low_cnt++;
      if (stall_prev) check("stall_hold", {bus.mem_cs_n, bus.mem_addr, bus.mem_wdata}, {1'b0, held});
      if (bus.mem_cs_n === 1'b0 && bus.mem_ry === 1'b1) begin
        check("we_n_eq_cs_n", bus.mem_we_n, bus.mem_cs_n);
        if (exp_q.size() == 0) check("write_unexpected", 1, exp_q.size());
        else check("write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
      stall_prev = (bus.mem_cs_n === 1'b0) && (bus.mem_ry === 1'b0);
      held = {bus.mem_addr, bus.mem_wdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    // Reset state
    reset_dut();
    check_reset_outputs("reset");
    check("reset_state_idle", state_dbg, 3'd0);

    // Matrix 0: bytes 0x00..0x1F gapless, mem_ry=1
    cs_low_cnt = 0;
    start_pulse();
    fill_seq(8'h00);
    expect_words(0, 8);
    send_bytes(0, 31, 1'b0);
    step();
    step();
    check("finish_not_early", bus.finish, 1'b0);
    step();
    check("finish_latency3", bus.finish, 1'b1);
    check("m0_all_done_low", bus.all_done, 1'b0);
    check("m0_writes_left", exp_q.size(), 0);
    check("m0_cs_low_cycles", cs_low_cnt, 8);
    check("m0_overflow", bus.overflow, 1'b0);

    // Valid pulses in WAIT are ignored, then matrix 1 with bytes 0x20..0x3F
    idle_pulses(4);
    check("wait_finish_held", bus.finish, 1'b1);
    check("wait_no_write", bus.mem_cs_n, 1'b1);
    start_pulse();
    check("finish_drop_on_start", bus.finish, 1'b0);
    fill_seq(8'h20);
    expect_words(1, 8);
    send_bytes(0, 31, 1'b0);
    wait_finish("m1_finish");
    check("m1_all_done", bus.all_done, 1'b1);
    check("m1_writes_left", exp_q.size(), 0);

    // A third start in DONE is ignored
    bus.start_in = 1'b1;
    bus.valid_input = 1'b1;
    step();
    bus.start_in = 1'b0;
    repeat (6) step();
    bus.valid_input = 1'b0;
    check("done_finish_held", bus.finish, 1'b1);
    check("done_all_done_held", bus.all_done, 1'b1);
    check("done_no_write", bus.mem_cs_n, 1'b1);

    // mem_ry low for 6 cycles from the first write
    reset_dut();
    start_pulse();
    fill_random();
    expect_words(0, 8);
    ry_lo = 5;
    ry_hi = 11;
    send_bytes(0, 31, 1'b0);
    wait_finish("stall_finish");
    check("stall_no_overflow", bus.overflow, 1'b0);
    check("stall_writes_left", exp_q.size(), 0);

    // mem_ry low for the whole matrix: words 0..2 survive, the rest drop
    reset_dut();
    start_pulse();
    fill_random();
    expect_words(0, 3);
    ry_lo = 0;
    ry_hi = 40;
    send_bytes(0, 11, 1'b0);
    check("ovf_before_word3", bus.overflow, 1'b0);
    send_bytes(12, 15, 1'b0);
    check("ovf_after_word3", bus.overflow, 1'b1);
    send_bytes(16, 31, 1'b0);
    wait_finish("ovf_finish");
    check("ovf_sticky", bus.overflow, 1'b1);
    check("ovf_writes_left", exp_q.size(), 0);

    // Random gaps, plus valid pulses in IDLE and WAIT
    reset_dut();
    idle_pulses(5);
    check("idle_no_write", bus.mem_cs_n, 1'b1);
    start_pulse();
    fill_random();
    expect_words(0, 8);
    send_bytes(0, 31, 1'b1);
    wait_finish("gap_m0_finish");
    idle_pulses(5);
    start_pulse();
    fill_random();
    expect_words(1, 8);
    send_bytes(0, 31, 1'b1);
    wait_finish("gap_m1_finish");
    check("gap_all_done", bus.all_done, 1'b1);
    check("gap_writes_left", exp_q.size(), 0);

    // Reset after byte 13 abandons the matrix; a fresh one starts at address 0
    reset_dut();
    start_pulse();
    fill_random();
    expect_words(0, 3);
    send_bytes(0, 13, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_outputs("midrst");
    check("midrst_writes_left", exp_q.size(), 0);
    step();
    start_pulse();
    fill_random();
    expect_words(0, 8);
    send_bytes(0, 31, 1'b0);
    wait_finish("midrst_finish");
    check("midrst_all_done_low", bus.all_done, 1'b0);
    check("midrst_final_writes_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
